// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one UART transmitter among N byte requesters
module uart_tx_arbiter #(
  parameter int N = 4,
  parameter int BUSY_TO = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic [7:0]     Tx_DATA,
  output logic           Tx_WR,
  output logic           Tx_EN,
  input  logic           Tx_BUSY,
  output logic           busy_err
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int CW = BUSY_TO > 1 ? $clog2(BUSY_TO) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT_HI = 2'd1, WAIT_LO = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] rr_ptr, winner, idx, sel;
  logic [CW-1:0] cnt;
  logic lock, issue_idle, issue_cont, issue;
  logic [N-1:0] onehot;
  // first requesting index after the last owner; scanning downward so the nearest one wins
  always_comb begin
    winner = rr_ptr;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(rr_ptr) + k) % N);
      if (req[idx]) winner = idx;
    end
  end
  // a byte goes out either from a fresh arbitration or as the locked owner's continuation
  always_comb begin
    issue_idle = state == IDLE && enable && |req;
    issue_cont = state == WAIT_LO && !Tx_BUSY && lock && enable && req[rr_ptr];
    issue = issue_idle | issue_cont;
    sel = issue_idle ? winner : rr_ptr;
    onehot = N'(1) << sel;
  end
  // byte sequencing: write strobe, wait for busy to rise (with timeout), wait for it to fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= PW'(N - 1);
      lock <= 1'b0;
      grant <= '0;
      req_ack <= '0;
      Tx_WR <= 1'b0;
      Tx_DATA <= '0;
      Tx_EN <= 1'b0;
      busy_err <= 1'b0;
      cnt <= '0;
    end else begin
      Tx_EN <= enable;
      Tx_WR <= issue;
      req_ack <= issue ? onehot : '0;
      busy_err <= 1'b0;
      if (issue) begin
        Tx_DATA <= req_data[{sel, 3'b000} +: 8];
        grant <= onehot;
        rr_ptr <= sel;
        lock <= ~req_last[sel];
        cnt <= '0;
        state <= WAIT_HI;
      end else if (state == WAIT_HI) begin
        if (Tx_BUSY) state <= WAIT_LO;
        else if (cnt == CW'(BUSY_TO - 1)) begin
          busy_err <= 1'b1;
          lock <= 1'b0;
          grant <= '0;
          state <= IDLE;
        end else cnt <= cnt + CW'(1);
      end else if (state == WAIT_LO && !Tx_BUSY) begin
        grant <= '0;
        lock <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule
